hazard_fwd_unit: RTL and testbench

//  Parametrised hazard and forwarding controller for the 5-stage in-order pipeline.

---
 rtl/hazard_fwd_unit.sv | 142 ++++++++++++++
 tb/tb_hazard_fwd_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit
//   Hazard and forwarding controller for the 5-stage in-order pipeline.
//   It keeps a shadow copy of the EX/MEM/WB destination registers and a
//   per-register busy counter. From these it produces the ID-stage stall,
//   the per-source EX forwarding selects, and a saturating count of stall
//   cycles.
// Ports
//   clk, rst      rising-edge clock, synchronous active-high reset
//   id_*          instruction presented in ID (valid, sources, dest, latency)
//   flush         squash the ID instruction this cycle
//   stall         hold PC and IF/ID, and insert a bubble into EX
//   forward       2 bits per EX source: 00 regfile, 01 EX/MEM, 10 MEM/WB
//   stall_cycles  number of cycles with stall=1, saturating at all-ones

// One source operand: the ID hazard check and the EX forward select.
module hazard_fwd_src #(
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] id_rs,
    input  logic              id_used,
    input  logic              id_busy,
    input  logic [ADDR_W-1:0] ex_rs,
    input  logic              ex_used,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic              wb_we,
    output logic              hazard,
    output logic [1:0]        fwd
);
    always_comb begin
        hazard = id_used && (id_rs != '0) && id_busy;
        fwd    = 2'b00;
        // The MEM slot holds the younger producer, so it is checked first.
        if (ex_used && (ex_rs != '0)) begin
            if (mem_we && (mem_rd == ex_rs))     fwd = 2'b01;
            else if (wb_we && (wb_rd == ex_rs))  fwd = 2'b10;
        end
    end
endmodule

module hazard_fwd_unit #(
    parameter int NUM_SRC = 2,
    parameter int ADDR_W  = 5,
    parameter int CNT_W   = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    input  logic [NUM_SRC*ADDR_W-1:0] id_rs_addr,
    input  logic [NUM_SRC-1:0]        id_rs_used,
    input  logic [ADDR_W-1:0]         id_rd_addr,
    input  logic                      id_reg_write,
    input  logic [1:0]                id_lat,
    input  logic                      flush,
    output logic                      stall,
    output logic [2*NUM_SRC-1:0]      forward,
    output logic [CNT_W-1:0]          stall_cycles
);
    localparam int NUM_REGS = 2 ** ADDR_W;

    // Remaining cycles before each register's pending result is forwardable.
    logic [NUM_REGS-1:0][1:0]        cnt_q, cnt_d;
    // Write-enable of the EX, MEM and WB shadows ([0]=EX, [1]=MEM, [2]=WB).
    logic [2:0]                      vld_pipe_q, vld_pipe_d;
    logic [2:0][ADDR_W-1:0]          rd_pipe_q, rd_pipe_d;
    logic [NUM_SRC-1:0][ADDR_W-1:0]  ex_rs_q, ex_rs_d;
    logic [NUM_SRC-1:0]              ex_rs_used_q, ex_rs_used_d;
    logic [CNT_W-1:0]                stall_cycles_q, stall_cycles_d;

    logic [NUM_SRC-1:0][ADDR_W-1:0]  id_rs;
    logic [NUM_SRC-1:0]              id_busy;
    logic [NUM_SRC-1:0]              hazard;
    logic [NUM_SRC-1:0][1:0]         fwd;
    logic                            accept;
    logic [1:0]                      lat_eff;

    assign id_rs = id_rs_addr;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        assign id_busy[k] = (cnt_q[id_rs[k]] != 2'd0);

        hazard_fwd_src #(.ADDR_W(ADDR_W)) u_src (
            .id_rs   (id_rs[k]),
            .id_used (id_rs_used[k]),
            .id_busy (id_busy[k]),
            .ex_rs   (ex_rs_q[k]),
            .ex_used (ex_rs_used_q[k]),
            .mem_rd  (rd_pipe_q[1]),
            .mem_we  (vld_pipe_q[1]),
            .wb_rd   (rd_pipe_q[2]),
            .wb_we   (vld_pipe_q[2]),
            .hazard  (hazard[k]),
            .fwd     (fwd[k])
        );
    end

    // Flush wins over stall: a squashed instruction never waits.
    assign stall        = id_valid && !flush && (|hazard);
    assign accept       = id_valid && !stall && !flush;
    assign lat_eff      = (id_lat == 2'd3) ? 2'd2 : id_lat;
    assign forward      = fwd;
    assign stall_cycles = stall_cycles_q;

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = (cnt_q[r] != 2'd0) ? cnt_q[r] - 2'd1 : 2'd0;
        end
        // A fresh issue overrides the decrement of its own destination.
        if (accept && id_reg_write && (id_rd_addr != '0)) begin
            cnt_d[id_rd_addr] = lat_eff;
        end

        vld_pipe_d    = {vld_pipe_q[1:0], accept && id_reg_write};
        rd_pipe_d     = {rd_pipe_q[1:0], accept ? id_rd_addr : {ADDR_W{1'b0}}};
        ex_rs_d       = accept ? id_rs : '0;
        ex_rs_used_d  = accept ? id_rs_used : '0;

        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q          <= '0;
            vld_pipe_q     <= '0;
            rd_pipe_q      <= '0;
            ex_rs_q        <= '0;
            ex_rs_used_q   <= '0;
            stall_cycles_q <= '0;
        end else begin
            cnt_q          <= cnt_d;
            vld_pipe_q     <= vld_pipe_d;
            rd_pipe_q      <= rd_pipe_d;
            ex_rs_q        <= ex_rs_d;
            ex_rs_used_q   <= ex_rs_used_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end
endmodule

// File: tb/tb_hazard_fwd_unit.sv
module tb_hazard_fwd_unit;
    localparam int NUM_SRC = 2;
    localparam int ADDR_W  = 5;
    localparam int CNT_W   = 3;
    localparam int NONE    = -1000;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      id_valid = 1'b0;
    logic [NUM_SRC*ADDR_W-1:0] id_rs_addr = '0;
    logic [NUM_SRC-1:0]        id_rs_used = '0;
    logic [ADDR_W-1:0]         id_rd_addr = '0;
    logic                      id_reg_write = 1'b0;
    logic [1:0]                id_lat = 2'd0;
    logic                      flush = 1'b0;
    logic                      stall;
    logic [2*NUM_SRC-1:0]      forward;
    logic [CNT_W-1:0]          stall_cycles;

    hazard_fwd_unit #(.NUM_SRC(NUM_SRC), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs_addr   (id_rs_addr),
        .id_rs_used   (id_rs_used),
        .id_rd_addr   (id_rd_addr),
        .id_reg_write (id_reg_write),
        .id_lat       (id_lat),
        .flush        (flush),
        .stall        (stall),
        .forward      (forward),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int exp_cnt = 0;
    int last_p [32];   // cycle in which the newest producer of each reg issued
    int last_l [32];   // its latency (3 folded to 2)
    logic [3:0] sb [$];  // expected EX forward for the next cycle

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic clear_model();
        for (int r = 0; r < 32; r++) begin
            last_p[r] = NONE;
            last_l[r] = 0;
        end
        sb.delete();
        sb.push_back(4'b0);
        exp_cnt = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst = 1'b0;
        clear_model();
    endtask

    // One cycle: drive ID, check stall/forward/counter, predict next EX.
    task automatic step(input logic v, input logic [4:0] r0, input logic [4:0] r1,
                        input logic [1:0] used, input logic [4:0] rd, input logic we,
                        input logic [1:0] lat, input logic fl);
        logic [4:0] rs [2];
        logic       exp_stall;
        logic [3:0] exp_fwd;
        logic [3:0] got_fwd;
        int         d;
        id_valid = v; id_rs_addr = {r1, r0}; id_rs_used = used;
        id_rd_addr = rd; id_reg_write = we; id_lat = lat; flush = fl;
        #1;
        rs[0] = r0; rs[1] = r1;
        // Producer issued at p with latency L blocks a reader through cycle p+L.
        exp_stall = 1'b0;
        if (v && !fl) begin
            for (int k = 0; k < 2; k++) begin
                if (used[k] && rs[k] != 0 && (cyc - last_p[rs[k]]) <= last_l[rs[k]])
                    exp_stall = 1'b1;
            end
        end
        chk("stall", {31'b0, stall}, {31'b0, exp_stall});
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
            got_fwd = 4'b0;
        end else begin
            got_fwd = sb.pop_front();
        end
        chk("forward", {28'b0, forward}, {28'b0, got_fwd});
        chk("stall_cycles", {29'b0, stall_cycles}, exp_cnt);
        if (exp_stall && exp_cnt != 7) exp_cnt++;

        exp_fwd = 4'b0;
        if (v && !exp_stall && !fl) begin
            for (int k = 0; k < 2; k++) begin
                if (used[k] && rs[k] != 0 && last_p[rs[k]] != NONE) begin
                    d = cyc + 1 - last_p[rs[k]];
                    if (d == 2)      exp_fwd[2*k +: 2] = 2'b01;
                    else if (d == 3) exp_fwd[2*k +: 2] = 2'b10;
                end
            end
            if (we && rd != 0) begin
                last_p[rd] = cyc;
                last_l[rd] = (lat == 2'd3) ? 2 : int'(lat);
            end
        end
        // A consumer the DUT lets into EX must find its operand forwardable.
        if (v && !stall && !fl) begin
            for (int k = 0; k < 2; k++) begin
                if (used[k] && rs[k] != 0 && last_p[rs[k]] != NONE && last_p[rs[k]] != cyc) begin
                    d = cyc + 1 - last_p[rs[k]];
                    chk("latency_guarantee", {31'b0, d >= 2 + last_l[rs[k]]}, 32'd1);
                end
            end
        end
        sb.push_back(exp_fwd);
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 2'd0, 1'b0);
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        idle();

        // ALU chain on x5
        step(1, 5'd1, 5'd2, 2'b11, 5'd5, 1, 2'd0, 0);
        step(1, 5'd5, 5'd3, 2'b01, 5'd11, 1, 2'd0, 0);
        step(1, 5'd5, 5'd0, 2'b01, 5'd12, 1, 2'd0, 0);
        idle(); idle(); idle();

        // Load-use on x6 through src1
        step(1, 5'd1, 5'd0, 2'b01, 5'd6, 1, 2'd1, 0);
        step(1, 5'd2, 5'd6, 2'b11, 5'd13, 1, 2'd0, 0);
        step(1, 5'd2, 5'd6, 2'b11, 5'd13, 1, 2'd0, 0);
        idle(); idle(); idle();

        // Long op on x7
        step(1, 5'd1, 5'd0, 2'b01, 5'd7, 1, 2'd2, 0);
        step(1, 5'd7, 5'd0, 2'b01, 5'd14, 1, 2'd0, 0);
        step(1, 5'd7, 5'd0, 2'b01, 5'd14, 1, 2'd0, 0);
        step(1, 5'd7, 5'd0, 2'b01, 5'd14, 1, 2'd0, 0);
        idle(); idle(); idle();

        // Back-to-back writers of x8, newest must win
        step(1, 5'd1, 5'd0, 2'b01, 5'd8, 1, 2'd0, 0);
        step(1, 5'd2, 5'd0, 2'b01, 5'd8, 1, 2'd0, 0);
        step(1, 5'd0, 5'd8, 2'b10, 5'd15, 1, 2'd0, 0);
        idle(); idle(); idle();

        // x0 writer and reader, and an unused source naming a busy register
        step(1, 5'd1, 5'd0, 2'b01, 5'd0, 1, 2'd2, 0);
        step(1, 5'd0, 5'd0, 2'b11, 5'd16, 1, 2'd0, 0);
        step(1, 5'd1, 5'd0, 2'b01, 5'd17, 1, 2'd2, 0);
        step(1, 5'd0, 5'd17, 2'b01, 5'd18, 1, 2'd0, 0);
        idle(); idle(); idle();

        // Flush in the load-use stall cycle; the squashed op also names x9 as rd
        step(1, 5'd1, 5'd0, 2'b01, 5'd9, 1, 2'd1, 0);
        step(1, 5'd9, 5'd0, 2'b01, 5'd9, 1, 2'd2, 1);
        step(1, 5'd9, 5'd0, 2'b01, 5'd19, 1, 2'd0, 0);
        idle(); idle(); idle();

        // Counter saturation with repeated long ops (lat=3 behaves as 2)
        for (int i = 0; i < 4; i++) begin
            step(1, 5'd1, 5'd0, 2'b01, 5'd20, 1, (i == 2) ? 2'd3 : 2'd2, 0);
            step(1, 5'd20, 5'd0, 2'b01, 5'd21, 1, 2'd0, 0);
            step(1, 5'd20, 5'd0, 2'b01, 5'd21, 1, 2'd0, 0);
            step(1, 5'd20, 5'd0, 2'b01, 5'd21, 1, 2'd0, 0);
        end
        idle(); idle();

        // Reset while a long op is in flight and its consumer waits in ID
        step(1, 5'd1, 5'd0, 2'b01, 5'd10, 1, 2'd2, 0);
        id_valid = 1; id_rs_addr = {5'd0, 5'd10}; id_rs_used = 2'b01;
        id_rd_addr = 5'd22; id_reg_write = 1; id_lat = 2'd0; flush = 0;
        do_reset();
        step(1, 5'd10, 5'd0, 2'b01, 5'd22, 1, 2'd0, 0);
        idle(); idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
